// File: rtl/count_pkg.sv
// count_pkg
//   Shared helpers for the count_updown_param counter family.
//   - clog2    : bits needed to hold 0..value-1, never less than 1.
//   - MODE_*   : encodings for the SATURATE parameter.
package count_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // A prescaler that only ever holds 0 still needs a 1-bit register,
    // so the result is clamped to at least 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Prescaler for count_updown_param. Counts enabled clocks 0..PRESCALE-1
//   and raises tick (combinational) on the enabled edge that closes a
//   period; the phase then returns to 0.
// Ports:
//   clk      in   system clock, rising edge
//   n_rst    in   synchronous active-low reset
//   en       in   advance the phase on this edge
//   restart  in   force the phase back to 0 (clear/load)
//   tick     out  step request for the current edge
module tick_divider
    import count_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int            PW   = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en & (phase == LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            phase <= '0;
        end else if (restart) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/count_updown_param.sv
// count_updown_param
//   General-purpose timer / event counter. Range 0..MAX_COUNT, counts up or
//   down once per prescaler tick, wraps or saturates at the limits.
// Ports:
//   clk       in   system clock, rising edge
//   n_rst     in   synchronous active-low reset
//   en        in   count enable (gates prescaler and stepping)
//   up        in   1 = increment, 0 = decrement
//   clr       in   synchronous clear of count, prescaler and ovf
//   load      in   synchronous load of load_val (clamped to MAX_COUNT)
//   load_val  in   load value
//   count     out  current count (registered)
//   tc        out  one-cycle pulse after a step taken at the limit
//   ovf       out  sticky over/underflow flag
//   at_limit  out  count sits at the limit for the current direction
module count_updown_param
    import count_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          PRESCALE  = 1,
    parameter int          SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic             tick;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    // Clear and load both restart the prescaler phase.
    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_div (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (en),
        .restart (clr | load),
        .tick    (tick)
    );

    assign at_limit = up ? (count == MAX_V) : (count == '0);

    // Priority clr > load > step; tc is only ever set by a limit step, so it
    // drops on every other edge.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;
        if (clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick) begin
            if (at_limit) begin
                tc_nxt  = 1'b1;
                ovf_nxt = 1'b1;
                // Saturate mode leaves count where it is.
                if (SATURATE == MODE_WRAP)
                    count_nxt = up ? '0 : MAX_V;
            end else begin
                count_nxt = up ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
